// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the binary-to-BCD converter and the
// display logic that consumes its packed digits.
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int ADD3_THRESH = 5;
    localparam int DEF_BIN_W   = 12;
    localparam int DEF_DIGITS  = 4;

    // Largest value representable in n decimal digits, plus one.
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // Inputs never exceed 9, so the sum stays within 4 bits (max 12).
    assign o_digit = (i_digit >= BCD_DIGIT_W'(ADD3_THRESH)) ?
                     i_digit + BCD_DIGIT_W'(3) : i_digit;

endmodule

// File: rtl/bcd_shift_converter.sv
// Sequential double-dabble converter: one binary bit per clock, result and a
// one-cycle rdy strobe presented on the edge of the final shift.
module bcd_shift_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [BIN_W-1:0]              bin_d_in,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_d_out,
    output logic                          rdy,
    output logic                          busy
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (((64'd1 << BIN_W) - 64'd1) > (pow10(DIGITS) - 64'd1)) begin : g_cfg_check
        $error("bcd_shift_converter: DIGITS too small to hold 2**BIN_W-1");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [BIN_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   r_bcd_out;
    logic               r_rdy;

    logic [BCD_W-1:0]   w_bcd_adj;
    logic [BCD_W-1:0]   w_bcd_shift;
    logic               w_accept;
    logic               w_last;
    logic               w_unused_msb;

    assign w_accept = (r_state == IDLE) && en;
    assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_W'(1));

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The adjusted top bit is always zero for legal configurations and falls
    // off the end of the {bcd,bin} shift.
    assign w_bcd_shift  = {w_bcd_adj[BCD_W-2:0], r_bin[BIN_W-1]};
    assign w_unused_msb = w_bcd_adj[BCD_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (en)     w_state_next = SHIFT;
            SHIFT:   if (w_last) w_state_next = IDLE;
            default:             w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_bcd_out <= '0;
            r_rdy     <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (w_accept) begin
                r_bin <= bin_d_in;
                r_bcd <= '0;
                r_cnt <= CNT_W'(BIN_W);
            end else if (r_state == SHIFT) begin
                r_bcd <= w_bcd_shift;
                r_bin <= {r_bin[BIN_W-2:0], 1'b0};
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_bcd_out <= w_bcd_shift;
                    r_rdy     <= 1'b1;
                end
            end
        end
    end

    assign bcd_d_out = r_bcd_out;
    assign rdy       = r_rdy;
    assign busy      = (r_state == SHIFT);

endmodule

// File: tb/tb_bcd_shift_converter.sv
// Randomized and directed bench for bcd_shift_converter against a decimal
// reference model computed with plain division.
module tb_bcd_shift_converter;

    localparam int BIN_W  = 12;
    localparam int DIGITS = 4;
    localparam int LAT    = BIN_W;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [11:0] bin_d_in;
    logic [15:0] bcd_d_out;
    logic        rdy;
    logic        busy;

    int n_vec;
    int n_err;
    logic [15:0] prev_exp;

    bcd_shift_converter #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .bin_d_in  (bin_d_in),
        .bcd_d_out (bcd_d_out),
        .rdy       (rdy),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Single en pulse; optionally raises en with a decoy operand inj_cyc edges
    // after the accept edge, which must be ignored while busy.
    task automatic convert(input int v, input int inj_cyc, input int inj_val);
        int cyc;
        bit got, stable, busy_ok, extra;
        logic [15:0] exp;
        exp = ref_bcd(v);
        @(negedge clk);
        en = 1'b1;
        bin_d_in = 12'(v);
        @(posedge clk);
        #1;
        en = 1'b0;
        bin_d_in = 12'($urandom_range(0, 4095));
        busy_ok = (busy == 1'b1) && (rdy == 1'b0);
        stable = (bcd_d_out == prev_exp);
        cyc = 0;
        got = 0;
        while (!got && cyc < 30) begin
            if (cyc == inj_cyc) begin
                en = 1'b1;
                bin_d_in = 12'(inj_val);
            end else begin
                en = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (rdy) begin
                got = 1;
            end else begin
                if (bcd_d_out != prev_exp) stable = 0;
                if (!busy) busy_ok = 0;
            end
        end
        en = 1'b0;
        chk("latency", cyc, LAT);
        chk("result", bcd_d_out, exp);
        chk("busy_at_rdy", busy, 0);
        chk("busy_during", busy_ok, 1);
        chk("hold_during", stable, 1);
        $display("conv bin=%0d bcd=%04h exp=%04h lat=%0d inj=%0d", v, bcd_d_out, exp, cyc, inj_cyc);
        prev_exp = exp;
        extra = 0;
        stable = 1;
        repeat (LAT + 2) begin
            @(posedge clk);
            #1;
            if (rdy || busy) extra = 1;
            if (bcd_d_out != exp) stable = 0;
        end
        chk("no_extra_rdy", extra, 0);
        chk("hold_idle", stable, 1);
    endtask

    // en held high; each rdy edge is immediately followed by the next accept.
    task automatic chain(input int vals[$]);
        int cyc;
        bit got, busy_ok, stable;
        logic [15:0] exp;
        @(negedge clk);
        en = 1'b1;
        bin_d_in = 12'(vals[0]);
        @(posedge clk);
        for (int i = 0; i < vals.size(); i++) begin
            exp = ref_bcd(vals[i]);
            #1;
            busy_ok = (busy == 1'b1) && (rdy == 1'b0);
            stable = (bcd_d_out == prev_exp);
            bin_d_in = 12'($urandom_range(0, 4095));
            cyc = 0;
            got = 0;
            while (!got && cyc < 30) begin
                @(posedge clk);
                #1;
                cyc++;
                if (rdy) begin
                    got = 1;
                end else begin
                    if (bcd_d_out != prev_exp) stable = 0;
                    if (!busy) busy_ok = 0;
                end
            end
            if (i + 1 < vals.size()) bin_d_in = 12'(vals[i+1]);
            else en = 1'b0;
            chk("chain_latency", cyc, LAT);
            chk("chain_result", bcd_d_out, exp);
            chk("chain_busy", busy_ok, 1);
            chk("chain_hold", stable, 1);
            $display("chain bin=%0d bcd=%04h exp=%04h lat=%0d", vals[i], bcd_d_out, exp, cyc);
            prev_exp = exp;
            if (i + 1 < vals.size()) @(posedge clk);
        end
    endtask

    task automatic reset_mid_conversion(input int v);
        bit saw_rdy;
        @(negedge clk);
        en = 1'b1;
        bin_d_in = 12'(v);
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_out", bcd_d_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_rdy = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (rdy || busy) saw_rdy = 1;
        end
        chk("rst_no_rdy", saw_rdy, 0);
        $display("reset abort bin=%0d out=%04h", v, bcd_d_out);
        prev_exp = '0;
    endtask

    initial begin
        int q[$];
        n_vec = 0;
        n_err = 0;
        prev_exp = '0;
        rst_n = 1'b0;
        en = 1'b0;
        bin_d_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", bcd_d_out, 0);
        chk("reset_rdy", rdy, 0);
        chk("reset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        convert(0, -1, 0);
        convert(4095, -1, 0);
        convert(999, -1, 0);
        convert(1234, -1, 0);
        convert(2468, 5, 7);

        q = {10, 20, 30};
        chain(q);

        reset_mid_conversion(3579);
        convert(1234, -1, 0);

        for (int i = 0; i < 200; i++) begin
            convert($urandom_range(0, 4095),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(0, LAT - 2) : -1,
                    $urandom_range(0, 4095));
        end

        q = {};
        for (int v = 0; v < 4096; v++) q.push_back(v);
        chain(q);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
